// File: rtl/fpu_addsub_pipe.sv
// ---------------------------------------------------------------------------
// fpu_addsub_pipe
//   Fully pipelined floating-point adder/subtractor with generic exponent and
//   mantissa widths (fp16 by default). One operation per cycle, four register
//   stages, subnormal support, full leading-zero normalisation, and
//   invalid / overflow / inexact flags.
//
// Build option:
//   FPU_ADDSUB_RNE_EN defined   : round-to-nearest-even, overflow gives +/-inf.
//   FPU_ADDSUB_RNE_EN undefined : truncation, overflow saturates to max finite.
//   Latency is the same in both builds.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      operation handshake (op_sub, a, b, in_tag)
//   op_sub                   0: a+b, 1: a-b
//   a, b                     packed operands {sign, exp, man}
//   in_tag                   opaque tag carried with the operation
//   out_valid / out_ready    result handshake (result, out_tag, flags)
//   result                   packed sum/difference
//   out_tag                  tag of the operation producing result
//   flag_invalid             NaN operand or inf-inf
//   flag_overflow            finite operands rounded past the largest finite
//   flag_inexact             rounding discarded nonzero bits
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A result held with out_valid=1 and out_ready=0 is a stall that
// freezes every stage (in_ready=0) and keeps result/out_tag/flags stable.
// Bubbles travel through the pipe and are never collapsed.
// ---------------------------------------------------------------------------
module fpu_addsub_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     op_sub,
  input  logic [EXP_W+MAN_W:0]     a,
  input  logic [EXP_W+MAN_W:0]     b,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [EXP_W+MAN_W:0]     result,
  output logic [TAG_W-1:0]         out_tag,
  output logic                     flag_invalid,
  output logic                     flag_overflow,
  output logic                     flag_inexact
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int FW  = MAN_W + 4;            // significand + guard/round/sticky
  localparam int SW  = MAN_W + 5;            // frame plus carry-out bit
  localparam int LZW = $clog2(SW + 1);
  localparam int CW  = ((LZW > EXP_W) ? LZW : EXP_W) + 1;

  localparam logic [EXP_W-1:0] EXP_ONES = {EXP_W{1'b1}};
  localparam logic [W-1:0]     QNAN     = {1'b0, EXP_ONES, 1'b1, {(MAN_W-1){1'b0}}};

  function automatic logic [LZW-1:0] f_lzc(input logic [SW-1:0] v);
    logic [LZW-1:0] n;
    logic           done;
    n    = '0;
    done = 1'b0;
    for (int i = SW - 1; i >= 0; i--) begin
      if (!done) begin
        if (v[i]) done = 1'b1;
        else      n = n + LZW'(1);
      end
    end
    return n;
  endfunction

  logic w_adv;
  assign w_adv    = ~(out_valid & ~out_ready);
  assign in_ready = w_adv;

  // ---------------- S1: unpack, classify, swap ----------------
  logic             w_sa, w_sb, w_swap;
  logic [EXP_W-1:0] w_ea, w_eb, w_ea_eff, w_eb_eff;
  logic [MAN_W-1:0] w_ma, w_mb;
  logic [MAN_W:0]   w_siga, w_sigb;
  logic             w_a_nan, w_b_nan, w_a_inf, w_b_inf;
  logic             w_inv1, w_spec1;
  logic [W-1:0]     w_spec_res1;

  assign w_sa     = a[W-1];
  assign w_sb     = b[W-1] ^ op_sub;
  assign w_ea     = a[W-2:MAN_W];
  assign w_eb     = b[W-2:MAN_W];
  assign w_ma     = a[MAN_W-1:0];
  assign w_mb     = b[MAN_W-1:0];
  assign w_a_nan  = (w_ea == EXP_ONES) & (|w_ma);
  assign w_b_nan  = (w_eb == EXP_ONES) & (|w_mb);
  assign w_a_inf  = (w_ea == EXP_ONES) & ~(|w_ma);
  assign w_b_inf  = (w_eb == EXP_ONES) & ~(|w_mb);
  // Subnormals: hidden bit 0, effective exponent 1.
  assign w_ea_eff = (w_ea == '0) ? EXP_W'(1) : w_ea;
  assign w_eb_eff = (w_eb == '0) ? EXP_W'(1) : w_eb;
  assign w_siga   = {|w_ea, w_ma};
  assign w_sigb   = {|w_eb, w_mb};
  // {exp,man} as an unsigned integer orders magnitudes directly.
  assign w_swap   = (b[W-2:0] > a[W-2:0]);
  assign w_inv1   = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
  assign w_spec1  = w_inv1 | w_a_inf | w_b_inf;
  assign w_spec_res1 = w_inv1  ? QNAN :
                       w_a_inf ? {w_sa, EXP_ONES, {MAN_W{1'b0}}} :
                                 {w_sb, EXP_ONES, {MAN_W{1'b0}}};

  logic             r1_valid, r1_sx, r1_sub, r1_zsign, r1_spec, r1_inv;
  logic [EXP_W-1:0] r1_ex, r1_ey;
  logic [MAN_W:0]   r1_mx, r1_my;
  logic [W-1:0]     r1_spec_res;
  logic [TAG_W-1:0] r1_tag;

  // ---------------- S2: align smaller operand ----------------
  logic [EXP_W-1:0] w_d;
  logic [31:0]      w_dc;
  logic [2*FW-1:0]  w_yext;
  logic [FW-1:0]    w_yal;

  assign w_d = r1_ex - r1_ey;
  always_comb begin
    w_dc = 32'(w_d);
    if (w_dc > 32'(FW)) w_dc = 32'(FW);
  end
  // Bits shifted into the lower half are ORed into the sticky position.
  assign w_yext = {r1_my, 3'b000, {FW{1'b0}}} >> w_dc;
  assign w_yal  = {w_yext[2*FW-1:FW+1], |w_yext[FW:0]};

  logic             r2_valid, r2_sx, r2_sub, r2_zsign, r2_spec, r2_inv;
  logic [EXP_W-1:0] r2_ex;
  logic [FW-1:0]    r2_mx, r2_my;
  logic [W-1:0]     r2_spec_res;
  logic [TAG_W-1:0] r2_tag;

  // ---------------- S3: add/subtract, leading-zero count ----------------
  logic [SW-1:0]  w_sum;
  // |X| >= |Y| guarantees the difference never goes negative.
  assign w_sum = r2_sub ? ({1'b0, r2_mx} - {1'b0, r2_my})
                        : ({1'b0, r2_mx} + {1'b0, r2_my});

  logic             r3_valid, r3_sx, r3_zsign, r3_spec, r3_inv;
  logic [EXP_W-1:0] r3_ex;
  logic [SW-1:0]    r3_sum;
  logic [LZW-1:0]   r3_lzc;
  logic [W-1:0]     r3_spec_res;
  logic [TAG_W-1:0] r3_tag;

  // ---------------- S4: normalise, round, pack ----------------
  logic             w_carry, w_zero, w_g, w_r, w_s, w_up, w_ovf, w_hid;
  logic [CW-1:0]    w_req, w_lim, w_sh;
  logic [FW-1:0]    w_nrm;
  logic [EXP_W:0]   w_enrm, w_efin;
  logic [MAN_W:0]   w_mant;
  logic [MAN_W+1:0] w_mant_r;
  logic [MAN_W-1:0] w_mfield;
  logic [W-1:0]     w_res;
  logic             w_f_inv, w_f_ovf, w_f_inx;

  assign w_carry = r3_sum[SW-1];
  assign w_zero  = (r3_sum == '0);
  // Left shift by lzc-1, but never take the exponent below 1.
  assign w_req   = CW'(r3_lzc) - CW'(1);
  assign w_lim   = CW'(r3_ex) - CW'(1);
  assign w_sh    = (w_req < w_lim) ? w_req : w_lim;
  assign w_nrm   = w_carry ? {r3_sum[SW-1:2], r3_sum[1] | r3_sum[0]}
                           : (r3_sum[FW-1:0] << w_sh);
  assign w_enrm  = w_carry ? ({1'b0, r3_ex} + (EXP_W+1)'(1))
                           : ({1'b0, r3_ex} - (EXP_W+1)'(w_sh));
  assign w_mant  = w_nrm[FW-1:3];
  assign w_g     = w_nrm[2];
  assign w_r     = w_nrm[1];
  assign w_s     = w_nrm[0];
`ifdef FPU_ADDSUB_RNE_EN
  assign w_up    = w_g & (w_r | w_s | w_mant[0]);
`else
  assign w_up    = 1'b0;
`endif
  assign w_mant_r = {1'b0, w_mant} + (MAN_W+2)'(w_up);
  assign w_efin   = w_mant_r[MAN_W+1] ? (w_enrm + (EXP_W+1)'(1)) : w_enrm;
  // Hidden bit absent after normalisation means a subnormal (exp field 0).
  assign w_hid    = w_mant_r[MAN_W+1] | w_mant_r[MAN_W];
  assign w_mfield = w_mant_r[MAN_W+1] ? w_mant_r[MAN_W:1] : w_mant_r[MAN_W-1:0];
  assign w_ovf    = (w_efin >= {1'b0, EXP_ONES});

  always_comb begin
    w_res   = {r3_sx, (w_hid ? w_efin[EXP_W-1:0] : {EXP_W{1'b0}}), w_mfield};
    w_f_inv = 1'b0;
    w_f_ovf = 1'b0;
    w_f_inx = w_g | w_r | w_s;
    if (r3_spec) begin
      w_res   = r3_spec_res;
      w_f_inv = r3_inv;
      w_f_inx = 1'b0;
    end else if (w_zero) begin
      w_res   = {r3_zsign, {(W-1){1'b0}}};
      w_f_inx = 1'b0;
    end else if (w_ovf) begin
`ifdef FPU_ADDSUB_RNE_EN
      w_res   = {r3_sx, EXP_ONES, {MAN_W{1'b0}}};
`else
      w_res   = {r3_sx, EXP_ONES - EXP_W'(1), {MAN_W{1'b1}}};
`endif
      w_f_ovf = 1'b1;
      w_f_inx = 1'b1;
    end
  end

  logic             r_out_valid, r_inv, r_ovf, r_inx;
  logic [W-1:0]     r_result;
  logic [TAG_W-1:0] r_out_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_valid    <= 1'b0;
      r2_valid    <= 1'b0;
      r3_valid    <= 1'b0;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_out_tag   <= '0;
      r_inv       <= 1'b0;
      r_ovf       <= 1'b0;
      r_inx       <= 1'b0;
    end else if (w_adv) begin
      r1_valid    <= in_valid;
      r1_sx       <= w_swap ? w_sb : w_sa;
      r1_ex       <= w_swap ? w_eb_eff : w_ea_eff;
      r1_ey       <= w_swap ? w_ea_eff : w_eb_eff;
      r1_mx       <= w_swap ? w_sigb : w_siga;
      r1_my       <= w_swap ? w_siga : w_sigb;
      r1_sub      <= w_sa ^ w_sb;
      // An exact zero is -0 only when both effective operands are negative.
      r1_zsign    <= w_sa & w_sb;
      r1_spec     <= w_spec1;
      r1_inv      <= w_inv1;
      r1_spec_res <= w_spec_res1;
      r1_tag      <= in_tag;

      r2_valid    <= r1_valid;
      r2_sx       <= r1_sx;
      r2_ex       <= r1_ex;
      r2_mx       <= {r1_mx, 3'b000};
      r2_my       <= w_yal;
      r2_sub      <= r1_sub;
      r2_zsign    <= r1_zsign;
      r2_spec     <= r1_spec;
      r2_inv      <= r1_inv;
      r2_spec_res <= r1_spec_res;
      r2_tag      <= r1_tag;

      r3_valid    <= r2_valid;
      r3_sx       <= r2_sx;
      r3_ex       <= r2_ex;
      r3_sum      <= w_sum;
      r3_lzc      <= f_lzc(w_sum);
      r3_zsign    <= r2_zsign;
      r3_spec     <= r2_spec;
      r3_inv      <= r2_inv;
      r3_spec_res <= r2_spec_res;
      r3_tag      <= r2_tag;

      r_out_valid <= r3_valid;
      if (r3_valid) begin
        r_result  <= w_res;
        r_out_tag <= r3_tag;
        r_inv     <= w_f_inv;
        r_ovf     <= w_f_ovf;
        r_inx     <= w_f_inx;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign result        = r_result;
  assign out_tag       = r_out_tag;
  assign flag_invalid  = r_inv;
  assign flag_overflow = r_ovf;
  assign flag_inexact  = r_inx;

endmodule

// File: tb/tb_fpu_addsub_pipe.sv
module tb_fpu_addsub_pipe;

  localparam int NV = 20;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_sub = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [3:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] result;
  logic [3:0]  out_tag;
  logic        flag_invalid, flag_overflow, flag_inexact;

  fpu_addsub_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op_sub(op_sub), .a(a), .b(b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag),
    .flag_invalid(flag_invalid), .flag_overflow(flag_overflow),
    .flag_inexact(flag_inexact)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // ---------------- reference model (exact integer arithmetic) ----------------
  // Returns {invalid, overflow, inexact, result[15:0]}.
  function automatic logic [18:0] model(input logic [15:0] fa, input logic [15:0] fb,
                                        input logic sub);
    logic        sa, sb, sg, inx, a_nan, b_nan, a_inf, b_inf;
    logic [4:0]  ea, eb, ef;
    logic [9:0]  ma, mb, mf;
    logic [63:0] va, vb, m, mant, rem, half;
    longint      s;
    int          p, sh, e;
    sa = fa[15]; sb = fb[15] ^ sub;
    ea = fa[14:10]; eb = fb[14:10];
    ma = fa[9:0];   mb = fb[9:0];
    a_nan = (ea == 5'h1f) && (ma != 0);
    b_nan = (eb == 5'h1f) && (mb != 0);
    a_inf = (ea == 5'h1f) && (ma == 0);
    b_inf = (eb == 5'h1f) && (mb == 0);
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) return {3'b100, 16'h7E00};
    if (a_inf) return {3'b000, sa, 5'h1f, 10'h0};
    if (b_inf) return {3'b000, sb, 5'h1f, 10'h0};
    // Values in units of the smallest subnormal.
    va = (ea == 0) ? {54'd0, ma} : ({53'd0, 1'b1, ma} << (ea - 1));
    vb = (eb == 0) ? {54'd0, mb} : ({53'd0, 1'b1, mb} << (eb - 1));
    s  = sa ? -longint'(va) : longint'(va);
    s  = s + (sb ? -longint'(vb) : longint'(vb));
    if (s == 0) return {3'b000, sa & sb, 15'd0};
    sg = (s < 0);
    m  = sg ? 64'(-s) : 64'(s);
    if (m < 64'd1024) begin
      mf = m[9:0];
      return {3'b000, sg, 5'd0, mf};
    end
    p = 10;
    while ((m >> (p + 1)) != 0) p++;
    sh   = p - 10;
    mant = m >> sh;
    rem  = m & ((64'd1 << sh) - 64'd1);
    e    = sh + 1;
    inx  = (rem != 0);
`ifdef FPU_ADDSUB_RNE_EN
    if (sh > 0) begin
      half = 64'd1 << (sh - 1);
      if ((rem > half) || ((rem == half) && mant[0])) mant = mant + 64'd1;
    end
    if (mant == 64'd2048) begin
      mant = 64'd1024;
      e    = e + 1;
    end
    if (e >= 31) return {3'b011, sg, 5'h1f, 10'h000};
`else
    half = '0;
    if (e >= 31) return {3'b011, sg, 5'h1e, 10'h3ff};
`endif
    ef = e[4:0];
    mf = mant[9:0];
    return {2'b00, inx, sg, ef, mf};
  endfunction

  // ---------------- directed vector table ----------------
  logic [15:0] tv_a   [NV];
  logic [15:0] tv_b   [NV];
  logic        tv_sub [NV];
  logic [15:0] tv_trn [NV];
  logic [15:0] tv_rne [NV];
  logic [2:0]  tv_ft  [NV];   // {invalid, overflow, inexact}, truncate build
  logic [2:0]  tv_fr  [NV];   // same, RNE build

  task automatic setv(input int i, input logic [15:0] va, input logic [15:0] vb,
                      input logic vs, input logic [15:0] rt, input logic [15:0] rr,
                      input logic [2:0] ft, input logic [2:0] fr);
    tv_a[i] = va; tv_b[i] = vb; tv_sub[i] = vs;
    tv_trn[i] = rt; tv_rne[i] = rr; tv_ft[i] = ft; tv_fr[i] = fr;
  endtask

  task automatic load_table();
    setv( 0, 16'h3C00, 16'h4000, 0, 16'h4200, 16'h4200, 3'b000, 3'b000); // 1+2
    setv( 1, 16'h3C01, 16'h3C00, 1, 16'h1400, 16'h1400, 3'b000, 3'b000); // cancellation
    setv( 2, 16'h3C00, 16'h3C00, 1, 16'h0000, 16'h0000, 3'b000, 3'b000); // x-x = +0
    setv( 3, 16'h7C00, 16'hFC00, 0, 16'h7E00, 16'h7E00, 3'b100, 3'b100); // inf-inf
    setv( 4, 16'h7C00, 16'h3C00, 0, 16'h7C00, 16'h7C00, 3'b000, 3'b000); // inf+1
    setv( 5, 16'h7BFF, 16'h7BFF, 0, 16'h7BFF, 16'h7C00, 3'b011, 3'b011); // overflow
    setv( 6, 16'h3C00, 16'h1000, 0, 16'h3C00, 16'h3C00, 3'b001, 3'b001); // tie, even
    setv( 7, 16'h3C01, 16'h1000, 0, 16'h3C01, 16'h3C02, 3'b001, 3'b001); // tie, odd
    setv( 8, 16'h8000, 16'h8000, 0, 16'h8000, 16'h8000, 3'b000, 3'b000); // -0 + -0
    setv( 9, 16'h8000, 16'h0000, 1, 16'h8000, 16'h8000, 3'b000, 3'b000); // -0 - +0
    setv(10, 16'h0001, 16'h0001, 0, 16'h0002, 16'h0002, 3'b000, 3'b000); // subnormals
    setv(11, 16'h03FF, 16'h0001, 0, 16'h0400, 16'h0400, 3'b000, 3'b000); // sub -> normal
    setv(12, 16'h0400, 16'h0001, 1, 16'h03FF, 16'h03FF, 3'b000, 3'b000); // normal -> sub
    setv(13, 16'h7E00, 16'h3C00, 0, 16'h7E00, 16'h7E00, 3'b100, 3'b100); // NaN operand
    setv(14, 16'hC000, 16'h3C00, 0, 16'hBC00, 16'hBC00, 3'b000, 3'b000); // -2+1
    setv(15, 16'h3C00, 16'h7BFF, 1, 16'hFBFE, 16'hFBFF, 3'b001, 3'b001); // 1-65504
    setv(16, 16'h7BFF, 16'h4C00, 0, 16'h7BFF, 16'h7C00, 3'b001, 3'b011); // round to ovf
    setv(17, 16'h3C00, 16'hBC00, 0, 16'h0000, 16'h0000, 3'b000, 3'b000); // 1+(-1)
    setv(18, 16'h4400, 16'h3C00, 1, 16'h4200, 16'h4200, 3'b000, 3'b000); // 4-1
    setv(19, 16'hFC00, 16'h7C00, 1, 16'hFC00, 16'hFC00, 3'b000, 3'b000); // -inf-inf
  endtask

  // ---------------- scoreboard / compare process ----------------
  logic [22:0] exp_q[$];       // {tag, invalid, overflow, inexact, result}
  logic        stall_prev = 1'b0;
  logic [22:0] held;

  always @(negedge clk) begin
    logic [22:0] e;
    if (rst) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid)
        chk("hold_stable", {9'd0, out_tag, flag_invalid, flag_overflow, flag_inexact, result},
            {9'd0, held});
      if (out_valid && !out_ready)
        chk("in_ready_stall", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("stale_output", {31'd0, out_valid}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_result", {16'd0, result}, {16'd0, e[15:0]});
          chk("sb_flags", {29'd0, flag_invalid, flag_overflow, flag_inexact}, {29'd0, e[18:16]});
          chk("sb_tag", {28'd0, out_tag}, {28'd0, e[22:19]});
        end
      end
      if (in_valid && in_ready)
        exp_q.push_back({in_tag, model(a, b, op_sub)});
      stall_prev = out_valid & ~out_ready;
      held       = {out_tag, flag_invalid, flag_overflow, flag_inexact, result};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int i, input logic [3:0] tag);
    int guard;
    @(posedge clk); #1;
    a = tv_a[i]; b = tv_b[i]; op_sub = tv_sub[i]; in_tag = tag; in_valid = 1'b1;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 32'd1, 32'd0);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic run_single(input int i);
    int lat;
    logic [15:0] er;
    logic [2:0]  ef;
`ifdef FPU_ADDSUB_RNE_EN
    er = tv_rne[i]; ef = tv_fr[i];
`else
    er = tv_trn[i]; ef = tv_ft[i];
`endif
    send(i, 4'(i));
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    chk($sformatf("latency_v%0d", i), lat, 32'd4);
    chk($sformatf("lit_result_v%0d", i), {16'd0, result}, {16'd0, er});
    chk($sformatf("lit_flags_v%0d", i), {29'd0, flag_invalid, flag_overflow, flag_inexact},
        {29'd0, ef});
    @(posedge clk); #1;
  endtask

  task automatic drain(input string name);
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || out_valid) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    chk(name, {31'd0, (guard >= 40)}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int out_before;
    load_table();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", {16'd0, result}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_flags", {29'd0, flag_invalid, flag_overflow, flag_inexact}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Isolated operations: latency plus literal expectations.
    for (int i = 0; i < NV; i++) run_single(i);

    // Back-to-back stream with a 3-cycle consumer stall.
    out_before = n_out;
    fork
      begin
        for (int i = 0; i < 8; i++) send(i + 5, 4'(i));
        idle();
      end
      begin
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain("drain_stall_stream");
    chk("stream_count", n_out - out_before, 32'd8);

    // Stream interrupted by a one-cycle reset.
    fork
      begin
        for (int i = 0; i < 8; i++) send(i + 10, 4'(8 + i));
        idle();
      end
      begin
        repeat (4) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result", {16'd0, result}, 32'd0);
      end
    join
    drain("drain_rst_stream");
    repeat (8) @(posedge clk);
    #1;
    chk("queue_empty", exp_q.size(), 32'd0);
    chk("idle_out_valid", {31'd0, out_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fpu_addsub_pipe.md
Name: fpu_addsub_pipe

Overview:
Parametrised, fully pipelined IEEE-754-style floating-point adder/subtractor. It is the successor to the single-issue fp16 adder FSM. Exponent and mantissa widths are generic, with fp16 as the default. The block accepts one operation per cycle under a valid/ready handshake, handles subnormals, performs full leading-zero normalisation, and reports exception flags. It sits in the FPU datapath between the operand-issue logic and the result writeback.

Parameters:
EXP_W, 5, exponent field width (bias = 2^(EXP_W-1)-1)
MAN_W, 10, stored mantissa width (hidden bit excluded)
TAG_W, 4, width of the opaque tag carried alongside each operation

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in_valid  in  1  operation present
in_ready  out  1  block can accept an operation this cycle
op_sub  in  1  0: a+b, 1: a-b (b sign inverted at entry)
a  in  1+EXP_W+MAN_W  operand A {sign, exp, man}
b  in  1+EXP_W+MAN_W  operand B
in_tag  in  TAG_W  opaque tag
out_valid  out  1  result present
out_ready  in  1  consumer accepts result
result  out  1+EXP_W+MAN_W  packed sum/difference
out_tag  out  TAG_W  tag of the matching operation
flag_invalid  out  1  NaN operand or inf-inf
flag_overflow  out  1  finite operands rounded to infinity
flag_inexact  out  1  rounding discarded nonzero bits

Behaviour:
- Single clock domain. Reset is synchronous, active-high, and sampled on the clk rising edge.
- Reset values: out_valid=0, result=0, out_tag=0, all flags=0. All stage valid bits clear.
- An operation is in flight after rst deasserts only if it was accepted after reset. Reset mid-operation discards all in-flight operations.
- Pipeline has 4 stages with fixed latency of 4 cycles from accept (in_valid&in_ready) to out_valid, absent stalls.
  - S1: unpack; subnormal detection (exp==0 gives hidden bit 0 and effective exp 1); NaN/inf classification; magnitude compare; swap so that |X|>=|Y|.
  - S2: right-shift Y by the exponent difference into an MAN_W+4 bit frame (guard, round, sticky). Shifts >= MAN_W+3 collapse to sticky only.
  - S3: add, or subtract the smaller magnitude from the larger (effective op = sign_a^sign_b^op_sub). Leading-zero count of the (MAN_W+5)-bit sum.
  - S4: normalise. On carry-out, shift right 1 and exp+1. On cancellation, shift left by LZC, clamped so that exp does not go below 1; a subnormal result follows. Then round, re-normalise on a rounding carry, and pack.
- Handshake:
  - stall = out_valid & ~out_ready. A stall freezes every stage.
  - in_ready = ~stall.
  - result, out_tag and the flags are held stable while out_valid & ~out_ready.
  - Bubbles propagate; they are not collapsed.
- Sign rules:
  - Exact zero result gives +0. Exception: (-0)+(-0), or (-0)-(+0), gives -0.
  - Otherwise the result sign is the sign of the larger-magnitude effective operand.
- Specials, decided in S1 and forwarded:
  - Any NaN operand, or inf+(-inf) effective, gives canonical qNaN {0, all-ones exp, 1 followed by MAN_W-1 zeros} and flag_invalid=1.
  - A single infinity, or same-sign infinities, gives that infinity with no flags.
- Overflow: a finite result whose exponent after rounding reaches all-ones gives ±inf, flag_overflow=1, flag_inexact=1.
- Underflow: subnormal results are produced exactly. There is no flush-to-zero.

Optional Feature:
FPU_ADDSUB_RNE_EN
- Defined: round-to-nearest-even using guard/round/sticky. flag_inexact = G|R|S.
- Undefined: truncation (round toward zero). Overflow saturates to max finite instead of inf; flag_overflow and flag_inexact still assert. flag_inexact = G|R|S.
- Latency is identical in both builds.

Test Plan:
- Add 0x3C00 + 0x4000, op_sub=0, out_ready=1 -> result 0x4200, out_valid exactly 4 cycles after accept, flags 0.
- Cancellation 0x3C01 - 0x3C00 (op_sub=1) -> 0x1400. Equal operands 0x3C00 - 0x3C00 -> 0x0000 (+0).
- Specials: 0x7C00 + 0xFC00 -> 0x7E00, flag_invalid=1. 0x7C00 + 0x3C00 -> 0x7C00, flags 0.
- Overflow 0x7BFF + 0x7BFF -> RNE build: 0x7C00 with flag_overflow=1; truncate build: 0x7BFF with flag_overflow=1.
- Rounding 0x3C00 + 0x1000 -> 0x3C00, inexact=1. 0x3C01 + 0x1000 -> RNE 0x3C02, truncate 0x3C01, inexact=1.
- Back-to-back stream of 8 ops with distinct tags:
  - Hold out_ready=0 for 3 cycles mid-stream -> in_ready=0 during the stall, outputs stable, no loss or duplication, tags in order.
  - Assert rst for one cycle mid-stream -> out_valid=0 next cycle, no stale results afterwards.
